// File: rtl/param_counter.sv
// Parametrised up/down counter with prescaler, load, wrap/saturate mode
// and a registered terminal-count pulse.
module param_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_limit
);

  if (MODULUS < 2 ||
      longint'(MODULUS) > (longint'(1) << WIDTH) ||
      PRESCALE < 1) begin : g_bad_param
    $error("param_counter: illegal MODULUS/PRESCALE");
  end

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam bit SAT = (SATURATE != 0);

  // Limit held at WIDTH+1 bits so MODULUS = 2**WIDTH stays exact.
  localparam logic [WIDTH:0] LIM = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] LIM_M1 = (WIDTH+1)'(MODULUS - 2);
  localparam logic [WIDTH-1:0] TOP = LIM[WIDTH-1:0];
  localparam logic [PW-1:0] PRE_END = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_pre;
  logic             r_tc;

  logic [WIDTH:0]   w_cnt_x;
  logic [WIDTH:0]   w_ld_x;
  logic             w_top;
  logic             w_zero;
  logic             w_step;
  logic [WIDTH-1:0] w_ld_val;

  assign w_cnt_x  = {1'b0, r_count};
  assign w_ld_x   = {1'b0, load_value};
  assign w_top    = (w_cnt_x == LIM);
  assign w_zero   = (r_count == '0);
  assign w_step   = enable && (r_pre == PRE_END);
  assign w_ld_val = (w_ld_x > LIM) ? TOP : load_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_pre   <= '0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= w_ld_val;
      r_pre   <= '0;
      r_tc    <= 1'b0;
    end else if (enable) begin
      r_pre <= w_step ? '0 : r_pre + PW'(1);
      r_tc  <= 1'b0;
      if (w_step) begin
        if (up_down) begin
          if (!w_top) begin
            r_count <= r_count + WIDTH'(1);
            // Saturating mode flags arrival at the top once
            r_tc    <= SAT && (w_cnt_x == LIM_M1);
          end else if (!SAT) begin
            r_count <= '0;
            r_tc    <= 1'b1;
          end
        end else begin
          if (!w_zero) begin
            r_count <= r_count - WIDTH'(1);
            r_tc    <= SAT && (r_count == WIDTH'(1));
          end else if (!SAT) begin
            r_count <= TOP;
            r_tc    <= 1'b1;
          end
        end
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign count    = r_count;
  assign tc       = r_tc;
  assign at_limit = up_down ? w_top : w_zero;

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter: several parameter sets share one
// stimulus stream; each test starts from a reset.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = '0;
  logic       up_down = 1'b1;

  logic [7:0] c_def, c_m10, c_ps4, c_sat, c_m100, c_ps3, c_m2;
  logic       t_def, t_m10, t_ps4, t_sat, t_m100, t_ps3, t_m2;
  logic       a_def, a_m10, a_ps4, a_sat, a_m100, a_ps3, a_m2;

  int n_chk = 0;
  int n_pass = 0;
  int n_tc = 0;

  always #5 clk = ~clk;

  param_counter u_def (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .up_down(up_down),
    .count(c_def), .tc(t_def), .at_limit(a_def));

  param_counter #(.MODULUS(10)) u_m10 (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .up_down(up_down),
    .count(c_m10), .tc(t_m10), .at_limit(a_m10));

  param_counter #(.PRESCALE(4)) u_ps4 (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .up_down(up_down),
    .count(c_ps4), .tc(t_ps4), .at_limit(a_ps4));

  param_counter #(.MODULUS(10), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .up_down(up_down),
    .count(c_sat), .tc(t_sat), .at_limit(a_sat));

  param_counter #(.MODULUS(100)) u_m100 (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .up_down(up_down),
    .count(c_m100), .tc(t_m100), .at_limit(a_m100));

  param_counter #(.PRESCALE(3)) u_ps3 (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .up_down(up_down),
    .count(c_ps3), .tc(t_ps3), .at_limit(a_ps3));

  param_counter #(.MODULUS(2)) u_m2 (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .up_down(up_down),
    .count(c_m2), .tc(t_m2), .at_limit(a_m2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    load = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_count", c_def, 0);
    chk("rst_tc", t_def, 0);
    chk("rst_lim_up", a_def, 0);
    up_down = 1'b0;
    #1;
    chk("rst_lim_dn", a_def, 1);

    // default wrap plus MODULUS=2 alternation
    reset = 1'b0;
    enable = 1'b1;
    up_down = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      chk("def_cnt", c_def, i % 256);
      chk("def_tc", t_def, (i == 256));
      chk("def_lim", a_def, (i == 255));
      if (i <= 4) begin
        chk("m2_cnt", c_m2, i % 2);
        chk("m2_tc", t_m2, (i % 2 == 0));
      end
    end

    // down wrap, MODULUS=10
    do_reset();
    up_down = 1'b0;
    enable = 1'b1;
    tick();
    chk("dn_first", c_m10, 9);
    chk("dn_first_tc", t_m10, 1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("dn_cnt", c_m10, 9 - k);
      chk("dn_tc", t_m10, 0);
    end
    chk("dn_lim", a_m10, 1);
    tick();
    chk("dn_wrap", c_m10, 9);
    chk("dn_wrap_tc", t_m10, 1);
    enable = 1'b0;
    tick();
    chk("dn_tc_drop", t_m10, 0);

    // prescaler 4
    do_reset();
    up_down = 1'b1;
    enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("ps4_cnt", c_ps4, i / 4);
    end
    tick();
    tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ps4_hold", c_ps4, 3);
    end
    enable = 1'b1;
    tick();
    chk("ps4_pre3", c_ps4, 3);
    tick();
    chk("ps4_step", c_ps4, 4);
    chk("ps4_tc", t_ps4, 0);

    // saturate up then down
    do_reset();
    up_down = 1'b1;
    enable = 1'b1;
    n_tc = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("sat_cnt", c_sat, (i < 9) ? i : 9);
      chk("sat_tc", t_sat, (i == 9));
      if (t_sat) n_tc++;
    end
    chk("sat_tc_once", n_tc, 1);
    chk("sat_lim", a_sat, 1);
    up_down = 1'b0;
    tick();
    chk("sat_dn", c_sat, 8);
    chk("sat_dn_tc", t_sat, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("sat_dn_cnt", c_sat, 8 - k);
      chk("sat_dn_arr", t_sat, (k == 8));
    end
    tick();
    chk("sat_hold0", c_sat, 0);
    chk("sat_hold_tc", t_sat, 0);

    // load, clamp and priority
    do_reset();
    up_down = 1'b1;
    load = 1'b1;
    load_value = 8'd200;
    tick();
    chk("ld_clamp", c_m100, 99);
    chk("ld_noclamp", c_def, 200);
    chk("ld_tc", t_m100, 0);
    enable = 1'b1;
    load_value = 8'd5;
    tick();
    chk("ld_en", c_m100, 5);
    load = 1'b0;
    tick();
    chk("ld_then_step", c_m100, 6);
    load = 1'b1;
    load_value = 8'd99;
    tick();
    chk("ld_top_lim", a_m100, 1);
    load = 1'b0;
    tick();
    chk("ld_top_wrap", c_m100, 0);
    chk("ld_top_tc", t_m100, 1);
    reset = 1'b1;
    load = 1'b1;
    load_value = 8'd7;
    tick();
    chk("rst_over_ld", c_m100, 0);
    load = 1'b0;

    // reset mid-prescale
    do_reset();
    enable = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_cnt", c_ps3, 0);
    chk("mid_rst_tc", t_ps3, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("mid_cnt", c_ps3, (i == 3));
      chk("mid_tc", t_ps3, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/param_counter.md
Name: param_counter

Overview:
- Parametrised successor to the team's fixed 8-bit free-running counter.
- Adds generic width, arbitrary modulus, up/down counting, a clock-enable prescaler, synchronous load, wrap or saturate mode, and a registered terminal-count pulse.
- Used directly as a timebase or event counter inside larger blocks.
- Driven from the MyHDL cosimulation bench through a thin DUT wrapper.

Parameters:
- WIDTH, 8: count register width in bits.
- MODULUS, 256: count range is 0 .. MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH.
- PRESCALE, 1: number of enabled cycles per count step. Must be >= 1.
- SATURATE, 0: 0 = wrap at the limits; 1 = hold at the limits.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  advances the prescaler when high.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value captured on load.
- up_down  in  1  count direction: 1 = up, 0 = down.
- count  out  WIDTH  registered count value.
- tc  out  1  registered terminal-count pulse.
- at_limit  out  1  count equals the limit in the current direction.

Behaviour:
- **Clocking and reset:** single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- **Reset values:** count=0, tc=0, internal prescaler=0. at_limit follows from count=0: 1 if up_down=0, otherwise 0 (unless MODULUS-1=0, which is illegal).
- **Priority each edge:** reset > load > enable step > hold.
- **Load:**
  - count <= load_value if load_value <= MODULUS-1; otherwise count <= MODULUS-1 (clamp).
  - Prescaler cleared to 0; tc <= 0.
  - enable is ignored on that edge.
- **Prescaler:**
  - When enable=1 and no load, the prescaler increments.
  - When prescaler == PRESCALE-1, a step occurs and the prescaler returns to 0.
  - PRESCALE=1 means a step on every enabled cycle.
  - enable=0 freezes the prescaler and count. The prescaler is not cleared by enable dropping or by a change of up_down.
- **Step up (up_down=1):**
  - count < MODULUS-1: count+1, tc <= 0.
  - count == MODULUS-1, SATURATE=0: count <= 0, tc <= 1.
  - count == MODULUS-1, SATURATE=1: count holds, tc <= 0.
  - SATURATE=1 and count reaches MODULUS-1 on this step: tc <= 1, once on arrival.
- **Step down (up_down=0):** mirror of step up. 0 wraps to MODULUS-1 with tc=1 when SATURATE=0. When SATURATE=1, tc=1 on arrival at 0, then count holds at 0 with tc=0.
- **tc timing:**
  - High for exactly one cycle, coincident with the updated count value.
  - 0 on every non-step cycle.
  - Back-to-back wraps (MODULUS=2, PRESCALE=1) give tc high on consecutive cycles.
- **at_limit:** combinational from the count register and up_down. 1 when (up_down=1 and count==MODULUS-1) or (up_down=0 and count==0). No latency.
- **Arithmetic:**
  - All compares are unsigned against MODULUS-1.
  - Wrap never produces count >= MODULUS.
  - MODULUS=2**WIDTH must not overflow the compare constant; compute it at WIDTH+1 bits.
- **Defaults:** with enable tied high and up_down=1, the block matches the previous counter exactly: 0..255 wrapping, count visible one cycle after each edge.
- **Reset mid-operation:** count and prescaler clear on that edge. The next step needs a full PRESCALE enabled cycles. Any pending tc is dropped.
- **Illegal parameters:** MODULUS outside 2..2**WIDTH, or PRESCALE < 1, stop elaboration with an error.

Test Plan:
- **Wrap at defaults:** defaults, reset 2 cycles, then enable=1, up_down=1 for 256 cycles -> count 1..255 then 0; tc=1 only on the cycle count=0; at_limit=1 while count=255.
- **Down wrap:** MODULUS=10, up_down=0 from reset, one enabled cycle -> count=9, tc=1 for one cycle; 9 more steps -> count=0, at_limit=1, next step -> 9 with tc=1.
- **Prescaler:** PRESCALE=4, enable=1 for 12 cycles -> count=3. Enable drop after 2 prescale cycles, wait 5, re-enable -> step after 2 more enabled cycles.
- **Saturate:** SATURATE=1, MODULUS=10, count up 12 steps -> count stops at 9, tc high exactly once (arrival step); then up_down=0, one step -> count=8, tc=0.
- **Load:** MODULUS=100, load=1 with load_value=200 -> count=99. load and enable together with load_value=5 -> count=5, no step. reset and load together -> count=0.
- **Reset mid-prescale:** PRESCALE=3, reset asserted after 2 enabled cycles -> count=0, prescaler=0; first step requires 3 further enabled cycles; tc=0 throughout.
